// File: rtl/axis_patgen_pkg.sv
// -----------------------------------------------------------------------------
// axis_patgen_pkg
// Shared types and constants for the AXI4-Stream pattern generator:
//   mode_e    - payload pattern selector (up-count, down-count, LFSR)
//   state_e   - generator FSM states
//   LFSR_MASK - Galois feedback mask for x^32+x^22+x^2+x+1
//   lfsr_step - one right-shift Galois step
// -----------------------------------------------------------------------------
package axis_patgen_pkg;

  typedef enum logic [1:0] {
    MODE_UP   = 2'd0,
    MODE_DOWN = 2'd1,
    MODE_LFSR = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_MASK : 32'h0);
  endfunction

endpackage

// File: rtl/axis_pattern_gen_if.sv
// -----------------------------------------------------------------------------
// axis_pattern_gen_if
// AXI4-Stream bus carried between the pattern generator and its sink.
//   tdata  [DATA_W]   payload
//   tkeep  [DATA_W/8] byte enables
//   tlast             last beat of packet
//   tvalid            beat valid (master -> slave)
//   tready            sink ready (slave -> master)
// Modports: master (generator side), slave (sink side).
// -----------------------------------------------------------------------------
interface axis_pattern_gen_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0]   tdata;
  logic [DATA_W/8-1:0] tkeep;
  logic                tlast;
  logic                tvalid;
  logic                tready;

  modport master (
    output tdata, tkeep, tlast, tvalid,
    input  tready
  );

  modport slave (
    input  tdata, tkeep, tlast, tvalid,
    output tready
  );
endinterface

// File: rtl/axis_patgen_lfsr32.sv
// -----------------------------------------------------------------------------
// axis_patgen_lfsr32
// 32-bit right-shift Galois LFSR used as the pseudo-random payload source.
//   aclk, aresetn - clock, asynchronous active-low reset
//   load          - take seed (a zero seed becomes 1, zero is a lock-up state)
//   advance       - step once; load has priority
//   seed  [32]    - initial state
//   state [32]    - current state
// -----------------------------------------------------------------------------
module axis_patgen_lfsr32
  import axis_patgen_pkg::*;
(
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        load,
  input  logic        advance,
  input  logic [31:0] seed,
  output logic [31:0] state
);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state <= 32'h1;
    end else if (load) begin
      state <= (seed == 32'h0) ? 32'h1 : seed;
    end else if (advance) begin
      state <= lfsr_step(state);
    end
  end

endmodule

// File: rtl/axis_pattern_gen.sv
// -----------------------------------------------------------------------------
// axis_pattern_gen
// AXI4-Stream master producing framed test traffic: up-count, down-count or
// LFSR payload with programmable packet length, packet count and gap.
//
// Build option: define AXIS_PATGEN_LFSR_EN to compile in the LFSR payload
// (DATA_W must then be a multiple of 32). Without it, mode 2 is up-count.
//
// Ports:
//   aclk, aresetn      clock, asynchronous active-low reset
//   enable             start request in IDLE, stop request at packet boundary
//   mode [2]           0 up, 1 down, 2 LFSR, 3 up
//   packet_size [CNT_W] beats per packet (0 means 1)
//   num_packets [PKT_W] packets per run (0 means continuous)
//   gap_cycles [GAP_W]  idle cycles between packets
//   seed [DATA_W]       first data word of a run
//   m_axis              AXI4-Stream master (axis_pattern_gen_if.master)
//   busy                high whenever the FSM is not IDLE
//   done                one-cycle pulse at the end of a counted run
//   pkt_cnt [PKT_W]     packets completed in the current run
// -----------------------------------------------------------------------------
module axis_pattern_gen
  import axis_patgen_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32,
  parameter int PKT_W  = 16,
  parameter int GAP_W  = 8
) (
  input  logic               aclk,
  input  logic               aresetn,
  input  logic               enable,
  input  logic [1:0]         mode,
  input  logic [CNT_W-1:0]   packet_size,
  input  logic [PKT_W-1:0]   num_packets,
  input  logic [GAP_W-1:0]   gap_cycles,
  input  logic [DATA_W-1:0]  seed,
  axis_pattern_gen_if.master m_axis,
  output logic               busy,
  output logic               done,
  output logic [PKT_W-1:0]   pkt_cnt
);

  if ((DATA_W % 8) != 0 || DATA_W < 8 || DATA_W > 512) begin : g_bad_data_w
    $error("axis_pattern_gen: DATA_W must be a multiple of 8 in 8..512");
  end

  state_e            state;
  mode_e             mode_q;
  mode_e             mode_in;
  logic [CNT_W-1:0]  last_beat_q;
  logic [CNT_W-1:0]  last_beat_in;
  logic [CNT_W-1:0]  beat_q;
  logic [PKT_W-1:0]  num_q;
  logic [PKT_W-1:0]  pkt_next;
  logic [GAP_W-1:0]  gap_q;
  logic [GAP_W-1:0]  gap_cnt;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] data_next;
  logic              tvalid_q;
  logic              tlast_q;
  logic              done_q;
  logic              handshake;

  // Mode 3 is reserved and folds onto up-count; mode 2 does too when the LFSR
  // is not compiled in.
  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    mode_in = MODE_UP;
    case (mode)
      2'd1:    mode_in = MODE_DOWN;
`ifdef AXIS_PATGEN_LFSR_EN
      2'd2:    mode_in = MODE_LFSR;
`endif
      default: mode_in = MODE_UP;
    endcase
  end

  // Storing size-1 lets tlast be a plain equality against the beat index.
  assign last_beat_in = (packet_size == '0) ? '0 : packet_size - CNT_W'(1);
  assign pkt_next     = pkt_cnt + PKT_W'(1);
  assign data_next    = (mode_q == MODE_DOWN) ? data_q - DATA_W'(1)
                                              : data_q + DATA_W'(1);
  assign handshake    = tvalid_q && m_axis.tready;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state       <= ST_IDLE;
      mode_q      <= MODE_UP;
      last_beat_q <= '0;
      beat_q      <= '0;
      num_q       <= '0;
      gap_q       <= '0;
      gap_cnt     <= '0;
      data_q      <= '0;
      pkt_cnt     <= '0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (enable) begin
            mode_q      <= mode_in;
            last_beat_q <= last_beat_in;
            num_q       <= num_packets;
            gap_q       <= gap_cycles;
            data_q      <= seed;
            beat_q      <= '0;
            pkt_cnt     <= '0;
            tvalid_q    <= 1'b1;
            tlast_q     <= (last_beat_in == '0);
            state       <= ST_RUN;
          end
        end

        ST_RUN: begin
          // Outputs only move on a handshake, which keeps tdata/tlast stable
          // under backpressure and never drops tvalid without a transfer.
          if (handshake) begin
            data_q <= data_next;
            if (tlast_q) begin
              pkt_cnt <= pkt_next;
              beat_q  <= '0;
              if (num_q != '0 && pkt_next == num_q) begin
                tvalid_q <= 1'b0;
                tlast_q  <= 1'b0;
                done_q   <= 1'b1;
                state    <= ST_DONE;
              end else if (!enable) begin
                tvalid_q <= 1'b0;
                tlast_q  <= 1'b0;
                state    <= ST_IDLE;
              end else if (gap_q != '0) begin
                tvalid_q <= 1'b0;
                tlast_q  <= 1'b0;
                gap_cnt  <= gap_q - GAP_W'(1);
                state    <= ST_GAP;
              end else begin
                tlast_q <= (last_beat_q == '0);
              end
            end else begin
              beat_q  <= beat_q + CNT_W'(1);
              tlast_q <= (beat_q + CNT_W'(1) == last_beat_q);
            end
          end
        end

        ST_GAP: begin
          // gap_cnt starts at G-1, giving exactly G idle cycles.
          if (gap_cnt == '0) begin
            tvalid_q <= 1'b1;
            tlast_q  <= (last_beat_q == '0);
            state    <= ST_RUN;
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef AXIS_PATGEN_LFSR_EN
  if ((DATA_W % 32) != 0) begin : g_bad_lfsr_w
    $error("axis_pattern_gen: DATA_W must be a multiple of 32 with LFSR enabled");
  end

  localparam int LANES = DATA_W / 32;

  logic [31:0] lfsr_state;

  axis_patgen_lfsr32 u_lfsr (
    .aclk    (aclk),
    .aresetn (aresetn),
    .load    ((state == ST_IDLE) && enable),
    .advance ((state == ST_RUN) && handshake && (mode_q == MODE_LFSR)),
    .seed    (seed[31:0]),
    .state   (lfsr_state)
  );

  assign m_axis.tdata = (mode_q == MODE_LFSR) ? {LANES{lfsr_state}} : data_q;
`else
  assign m_axis.tdata = data_q;
`endif

  assign m_axis.tkeep  = '1;
  assign m_axis.tlast  = tlast_q;
  assign m_axis.tvalid = tvalid_q;
  assign busy          = (state != ST_IDLE);
  assign done          = done_q;

endmodule
